// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM, and
// fills the IF/ID register. Handles stall, redirect/flush, and fetch faults
// (out-of-range PC or misaligned redirect). A fault stops fetch until reset.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IMEM_AW   = 8,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        pc_out,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc_plus4,
  output logic [31:0]        id_instr,
  output logic               id_valid,
  output logic               halted,
  output logic [31:0]        fault_pc,
  output logic [31:0]        fetch_count
);

  typedef enum logic {RUN, HALT} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  // Any PC bit at or above the ROM byte-address width means out of range.
  localparam logic [31:0] RANGE_MASK = ~((32'd1 << (IMEM_AW + 2)) - 32'd1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  ifid_t       ifid_q, ifid_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic [31:0] pc_plus4;
  logic        misaligned;
  logic        out_of_range;

  assign pc_plus4     = pc_q + 32'd4;
  assign misaligned   = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign out_of_range = |(pc_q & RANGE_MASK);

  // Next-state: HALT freezes everything but forces the bubble; in RUN the
  // priority is misaligned redirect, redirect, stall, range fault, capture.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ifid_d        = ifid_q;
    fault_pc_d    = fault_pc_q;
    fetch_count_d = fetch_count_q;
    if (state_q == HALT) begin
      ifid_d.valid = 1'b0;
      ifid_d.instr = NOP_INSTR;
    end else if (misaligned) begin
      state_d      = HALT;
      fault_pc_d   = redirect_pc;
      ifid_d.valid = 1'b0;
      ifid_d.instr = NOP_INSTR;
    end else if (redirect_valid) begin
      pc_d         = {redirect_pc[31:2], 2'b00};
      ifid_d.valid = 1'b0;
      ifid_d.instr = NOP_INSTR;
    end else if (stall) begin
      // hold PC and IF/ID
    end else if (out_of_range) begin
      state_d      = HALT;
      fault_pc_d   = pc_q;
      ifid_d.valid = 1'b0;
      ifid_d.instr = NOP_INSTR;
    end else begin
      pc_d          = pc_plus4;
      ifid_d.pc     = pc_q;
      ifid_d.instr  = imem_rdata;
      ifid_d.valid  = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  // State registers with synchronous reset that overrides all inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      ifid_q        <= '{pc: 32'd0, instr: NOP_INSTR, valid: 1'b0};
      fault_pc_q    <= 32'd0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ifid_q        <= ifid_d;
      fault_pc_q    <= fault_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q[IMEM_AW+1:2];
  assign pc_out      = pc_q;
  assign id_pc       = ifid_q.pc;
  assign id_pc_plus4 = ifid_q.pc + 32'd4;
  assign id_instr    = ifid_q.instr;
  assign id_valid    = ifid_q.valid;
  assign halted      = (state_q == HALT);
  assign fault_pc    = fault_pc_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, a run-past-ROM-end sequence,
// and randomized traffic checked against a behavioural fetch model.
module tb_if_stage;
  localparam int AW = 5;
  localparam int DEPTH = 1 << AW;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst, stall, redirect_valid;
  logic [31:0]   redirect_pc, imem_rdata;
  logic [AW-1:0] imem_addr;
  logic [31:0]   pc_out, id_pc, id_pc_plus4, id_instr, fault_pc, fetch_count;
  logic          id_valid, halted;

  logic [31:0] rom [0:DEPTH-1];
  assign imem_rdata = rom[imem_addr];

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0), .IMEM_AW(AW), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pc_out(pc_out), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
    .id_instr(id_instr), .id_valid(id_valid), .halted(halted),
    .fault_pc(fault_pc), .fetch_count(fetch_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: the fetch unit described as "what the next fetch does".
  logic [31:0] m_pc, m_id_pc, m_instr, m_fpc, m_cnt;
  logic        m_valid, m_halt;

  task automatic model(input logic r, input logic s, input logic v, input logic [31:0] p);
    if (r) begin
      m_pc = 0; m_id_pc = 0; m_instr = NOP; m_valid = 0;
      m_halt = 0; m_fpc = 0; m_cnt = 0;
    end else if (m_halt) begin
      m_valid = 0; m_instr = NOP;
    end else if (v && (p % 4 != 0)) begin
      m_halt = 1; m_fpc = p; m_valid = 0; m_instr = NOP;
    end else if (v) begin
      m_pc = p - (p % 4); m_valid = 0; m_instr = NOP;
    end else if (s) begin
      // nothing moves
    end else if (m_pc >= DEPTH * 4) begin
      m_halt = 1; m_fpc = m_pc; m_valid = 0; m_instr = NOP;
    end else begin
      m_instr = rom[m_pc / 4]; m_id_pc = m_pc; m_valid = 1;
      m_cnt = m_cnt + 1; m_pc = m_pc + 4;
    end
  endtask

  task automatic step(input logic r, input logic s, input logic v, input logic [31:0] p);
    @(negedge clk);
    rst = r; stall = s; redirect_valid = v; redirect_pc = p;
    @(posedge clk);
    model(r, s, v, p);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [31:0] exp_addr;
    exp_addr = (m_pc / 4) % DEPTH;
    chk({tag, ".pc_out"}, pc_out, m_pc);
    chk({tag, ".imem_addr"}, {{(32-AW){1'b0}}, imem_addr}, exp_addr);
    chk({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, m_valid});
    chk({tag, ".id_instr"}, id_instr, m_instr);
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, m_halt});
    chk({tag, ".fault_pc"}, fault_pc, m_fpc);
    chk({tag, ".fetch_count"}, fetch_count, m_cnt);
    if (m_valid) begin
      chk({tag, ".id_pc"}, id_pc, m_id_pc);
      chk({tag, ".id_pc_plus4"}, id_pc_plus4, m_id_pc + 4);
    end
  endtask

  typedef struct {
    logic        rst, stall, rv;
    logic [31:0] rpc;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_instr, e_id_pc;
    logic        e_halt;
    logic [31:0] e_fpc, e_cnt;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [31:0] rom16;
    rst = 1; stall = 0; redirect_valid = 0; redirect_pc = 0;
    for (int i = 0; i < DEPTH; i++) rom[i] = 32'h1000_0000 + i;
    rom[0] = 32'h00500093; rom[1] = 32'h00a00113;
    rom[2] = 32'h002081b3; rom[3] = 32'h00000013;
    rom16 = rom[16];

    //         rst stl rv  rpc     pc      vld instr         id_pc  hlt fpc     cnt
    tbl[0]  = '{1, 0, 0, 32'h00, 32'h00, 0, NOP,          32'h0,  0, 32'h0,  0};
    tbl[1]  = '{0, 0, 0, 32'h00, 32'h04, 1, 32'h00500093, 32'h0,  0, 32'h0,  1};
    tbl[2]  = '{0, 0, 0, 32'h00, 32'h08, 1, 32'h00a00113, 32'h4,  0, 32'h0,  2};
    tbl[3]  = '{0, 1, 0, 32'h00, 32'h08, 1, 32'h00a00113, 32'h4,  0, 32'h0,  2};
    tbl[4]  = '{0, 1, 0, 32'h00, 32'h08, 1, 32'h00a00113, 32'h4,  0, 32'h0,  2};
    tbl[5]  = '{0, 0, 0, 32'h00, 32'h0C, 1, 32'h002081b3, 32'h8,  0, 32'h0,  3};
    tbl[6]  = '{0, 1, 1, 32'h40, 32'h40, 0, NOP,          32'h0,  0, 32'h0,  3};
    tbl[7]  = '{0, 0, 0, 32'h00, 32'h44, 1, rom16,        32'h40, 0, 32'h0,  4};
    tbl[8]  = '{0, 0, 1, 32'h42, 32'h44, 0, NOP,          32'h0,  1, 32'h42, 4};
    tbl[9]  = '{0, 0, 1, 32'h00, 32'h44, 0, NOP,          32'h0,  1, 32'h42, 4};
    tbl[10] = '{0, 1, 0, 32'h00, 32'h44, 0, NOP,          32'h0,  1, 32'h42, 4};
    tbl[11] = '{1, 0, 0, 32'h00, 32'h00, 0, NOP,          32'h0,  0, 32'h0,  0};
    tbl[12] = '{0, 0, 0, 32'h00, 32'h04, 1, 32'h00500093, 32'h0,  0, 32'h0,  1};
    tbl[13] = '{0, 1, 0, 32'h00, 32'h04, 1, 32'h00500093, 32'h0,  0, 32'h0,  1};
    tbl[14] = '{1, 1, 0, 32'h00, 32'h00, 0, NOP,          32'h0,  0, 32'h0,  0};
    tbl[15] = '{0, 0, 0, 32'h00, 32'h04, 1, 32'h00500093, 32'h0,  0, 32'h0,  1};

    // Directed vectors with hand-derived expectations.
    for (int i = 0; i < 16; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      step(tbl[i].rst, tbl[i].stall, tbl[i].rv, tbl[i].rpc);
      chk({t, ".pc_out"}, pc_out, tbl[i].e_pc);
      chk({t, ".id_valid"}, {31'd0, id_valid}, {31'd0, tbl[i].e_valid});
      chk({t, ".id_instr"}, id_instr, tbl[i].e_instr);
      chk({t, ".halted"}, {31'd0, halted}, {31'd0, tbl[i].e_halt});
      chk({t, ".fault_pc"}, fault_pc, tbl[i].e_fpc);
      chk({t, ".fetch_count"}, fetch_count, tbl[i].e_cnt);
      if (tbl[i].e_valid || tbl[i].rst) begin
        chk({t, ".id_pc"}, id_pc, tbl[i].e_id_pc);
        chk({t, ".id_pc_plus4"}, id_pc_plus4, tbl[i].e_id_pc + 4);
      end
    end

    // Free run off the end of the ROM: every word fetched once, then fault.
    step(1, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 0, 0);
      check_model("run");
    end
    chk("run.count_at_end", fetch_count, DEPTH);
    chk("run.pc_at_end", pc_out, DEPTH * 4);
    step(0, 0, 0, 0);
    chk("end.halted", {31'd0, halted}, 32'd1);
    chk("end.fault_pc", fault_pc, DEPTH * 4);
    chk("end.fetch_count", fetch_count, DEPTH);
    chk("end.id_valid", {31'd0, id_valid}, 32'd0);
    step(0, 0, 1, 32'h10);
    chk("end.redirect_ignored", pc_out, DEPTH * 4);

    // Randomized traffic against the model.
    step(1, 0, 0, 0);
    check_model("rnd_rst");
    for (int i = 0; i < 3000; i++) begin
      logic r, s, v;
      logic [31:0] p;
      int sel;
      r = ($urandom_range(0, 99) < 2);
      s = ($urandom_range(0, 99) < 25);
      v = ($urandom_range(0, 99) < 12);
      sel = $urandom_range(0, 19);
      if (sel == 0)      p = {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(1, 3));
      else if (sel == 1) p = 32'(DEPTH * 4) + 32'($urandom_range(0, 15) * 4);
      else if (sel == 2) p = 32'($urandom_range(DEPTH - 3, DEPTH - 1) * 4);
      else               p = 32'($urandom_range(0, DEPTH - 1) * 4);
      step(r, s, v, p);
      check_model("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
